// File: rtl/cfu_pkg.sv
// Shared CFU command definitions used by the command queue, the compute core
// and their benches.
package cfu_pkg;

  localparam int CFU_FUNC_ID_W = 10;
  localparam int CFU_DATA_W    = 32;

  typedef struct packed {
    logic [CFU_FUNC_ID_W-1:0] function_id;
    logic [CFU_DATA_W-1:0]    inputs_0;
    logic [CFU_DATA_W-1:0]    inputs_1;
  } cfu_cmd_t;

  localparam int CFU_CMD_W = $bits(cfu_cmd_t);

endpackage

// File: rtl/cfu_queue_mem.sv
// Command storage for the CFU queue: one synchronous write port and one
// asynchronous read port. The array is never reset.
module cfu_queue_mem
  import cfu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  cfu_cmd_t          wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output cfu_cmd_t          rd_data
);

  cfu_cmd_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cfu_cmd_queue.sv
// In-order command buffer between the CPU CFU command bus and a multi-cycle
// compute core. No bypass path: a pushed command appears one cycle later.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1; valid never waits on ready, and cmd_ready never depends on core_cmd_ready.
module cfu_cmd_queue
  import cfu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CFU_FUNC_ID_W-1:0] cmd_payload_function_id,
  input  logic [CFU_DATA_W-1:0]    cmd_payload_inputs_0,
  input  logic [CFU_DATA_W-1:0]    cmd_payload_inputs_1,
  output logic                     core_cmd_valid,
  input  logic                     core_cmd_ready,
  output logic [CFU_FUNC_ID_W-1:0] core_cmd_payload_function_id,
  output logic [CFU_DATA_W-1:0]    core_cmd_payload_inputs_0,
  output logic [CFU_DATA_W-1:0]    core_cmd_payload_inputs_1,
  output logic [ADDR_W:0]          level
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            running;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  cfu_cmd_t        wr_cmd;
  cfu_cmd_t        head_cmd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign cmd_ready      = running && !full;
  assign core_cmd_valid = !empty;
  assign push           = cmd_valid && cmd_ready;
  assign pop            = core_cmd_valid && core_cmd_ready;
  assign level          = wr_ptr - rd_ptr;

  // running holds cmd_ready low while reset is asserted and opens it on the
  // first edge afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      running <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

  always_comb begin
    wr_cmd             = '0;
    wr_cmd.function_id = cmd_payload_function_id;
    wr_cmd.inputs_0    = cmd_payload_inputs_0;
    wr_cmd.inputs_1    = cmd_payload_inputs_1;
  end

  cfu_queue_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_cmd),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (head_cmd)
  );

  // Stale storage stays hidden: the head is forced to zero whenever empty.
  always_comb begin
    core_cmd_payload_function_id = '0;
    core_cmd_payload_inputs_0    = '0;
    core_cmd_payload_inputs_1    = '0;
    if (!empty) begin
      core_cmd_payload_function_id = head_cmd.function_id;
      core_cmd_payload_inputs_0    = head_cmd.inputs_0;
      core_cmd_payload_inputs_1    = head_cmd.inputs_1;
    end
  end

endmodule

// File: tb/tb_cfu_cmd_queue.sv
// Self-checking bench for cfu_cmd_queue: table vectors for the basic and
// full/empty cases, hand sequences for streaming, flush and async reset.
module tb_cfu_cmd_queue;
  import cfu_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [CFU_FUNC_ID_W-1:0] cmd_payload_function_id;
  logic [CFU_DATA_W-1:0]    cmd_payload_inputs_0;
  logic [CFU_DATA_W-1:0]    cmd_payload_inputs_1;
  logic                     core_cmd_valid;
  logic                     core_cmd_ready;
  logic [CFU_FUNC_ID_W-1:0] core_cmd_payload_function_id;
  logic [CFU_DATA_W-1:0]    core_cmd_payload_inputs_0;
  logic [CFU_DATA_W-1:0]    core_cmd_payload_inputs_1;
  logic [ADDR_W:0]          level;

  cfu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .flush                        (flush),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .cmd_payload_function_id      (cmd_payload_function_id),
    .cmd_payload_inputs_0         (cmd_payload_inputs_0),
    .cmd_payload_inputs_1         (cmd_payload_inputs_1),
    .core_cmd_valid               (core_cmd_valid),
    .core_cmd_ready               (core_cmd_ready),
    .core_cmd_payload_function_id (core_cmd_payload_function_id),
    .core_cmd_payload_inputs_0    (core_cmd_payload_inputs_0),
    .core_cmd_payload_inputs_1    (core_cmd_payload_inputs_1),
    .level                        (level)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [CFU_CMD_W-1:0] exp_q[$];
  logic                 mdl_run = 1'b0;
  int                   checks  = 0;
  int                   errors  = 0;

  function automatic logic [CFU_CMD_W-1:0] dut_head();
    return {core_cmd_payload_function_id, core_cmd_payload_inputs_0,
            core_cmd_payload_inputs_1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cmd(input string name, input logic [CFU_CMD_W-1:0] act,
                           input logic [CFU_CMD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle's inputs at the falling edge, then check the outputs
  // against the queue model.
  task automatic drive(input logic v, input logic [9:0] fid, input logic [31:0] i0,
                       input logic [31:0] i1, input logic cr, input logic fl);
    @(negedge clk);
    cmd_valid               = v;
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0    = i0;
    cmd_payload_inputs_1    = i1;
    core_cmd_ready          = cr;
    flush                   = fl;
    #1;
    check("mdl_level", 32'(level), 32'(exp_q.size()));
    check("mdl_cmd_ready", 32'(cmd_ready), 32'(mdl_run && (exp_q.size() < DEPTH)));
    check("mdl_core_valid", 32'(core_cmd_valid), 32'(exp_q.size() > 0));
    check_cmd("mdl_head", dut_head(), (exp_q.size() > 0) ? exp_q[0] : '0);
  endtask

  // Apply the model's view of this edge, then let the edge happen.
  task automatic commit();
    logic do_push;
    logic do_pop;
    logic [CFU_CMD_W-1:0] exp_cmd;
    do_push = cmd_valid && mdl_run && (exp_q.size() < DEPTH) && !flush;
    do_pop  = (exp_q.size() > 0) && core_cmd_ready && !flush;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) begin
        exp_cmd = exp_q.pop_front();
        check_cmd("pop_data", dut_head(), exp_cmd);
      end
      if (do_push) begin
        exp_q.push_back({cmd_payload_function_id, cmd_payload_inputs_0,
                         cmd_payload_inputs_1});
      end
    end
    @(posedge clk);
  endtask

  task automatic step(input logic v, input logic [9:0] fid, input logic [31:0] i0,
                      input logic [31:0] i1, input logic cr, input logic fl);
    drive(v, fid, i0, i1, cr, fl);
    commit();
  endtask

  // Assert reset mid-cycle, check reset values immediately, release it.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    flush     = 1'b0;
    #1;
    exp_q.delete();
    mdl_run = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_core_valid", 32'(core_cmd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check_cmd("rst_head", dut_head(), '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    mdl_run = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] i0;
    logic        cr;
    logic [2:0]  exp_level;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_i0;
  } vec_t;

  vec_t tbl[19];

  initial begin
    reset                   = 1'b1;
    flush                   = 1'b0;
    cmd_valid               = 1'b0;
    core_cmd_ready          = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;

    // Columns: valid, in0, core_ready | level, core_valid, cmd_ready, head in0
    // (expected values are those seen before the edge of that row).
    tbl[0]  = '{1'b0, 32'd0,  1'b0, 3'd0, 1'b0, 1'b1, 32'd0};
    tbl[1]  = '{1'b1, 32'd10, 1'b0, 3'd0, 1'b0, 1'b1, 32'd0};
    tbl[2]  = '{1'b0, 32'd0,  1'b0, 3'd1, 1'b1, 1'b1, 32'd10};
    tbl[3]  = '{1'b0, 32'd0,  1'b0, 3'd1, 1'b1, 1'b1, 32'd10};
    tbl[4]  = '{1'b0, 32'd0,  1'b0, 3'd1, 1'b1, 1'b1, 32'd10};
    tbl[5]  = '{1'b0, 32'd0,  1'b0, 3'd1, 1'b1, 1'b1, 32'd10};
    tbl[6]  = '{1'b0, 32'd0,  1'b0, 3'd1, 1'b1, 1'b1, 32'd10};
    tbl[7]  = '{1'b0, 32'd0,  1'b1, 3'd1, 1'b1, 1'b1, 32'd10};
    tbl[8]  = '{1'b0, 32'd0,  1'b0, 3'd0, 1'b0, 1'b1, 32'd0};
    tbl[9]  = '{1'b1, 32'd1,  1'b0, 3'd0, 1'b0, 1'b1, 32'd0};
    tbl[10] = '{1'b1, 32'd2,  1'b0, 3'd1, 1'b1, 1'b1, 32'd1};
    tbl[11] = '{1'b1, 32'd3,  1'b0, 3'd2, 1'b1, 1'b1, 32'd1};
    tbl[12] = '{1'b1, 32'd4,  1'b0, 3'd3, 1'b1, 1'b1, 32'd1};
    tbl[13] = '{1'b1, 32'd5,  1'b0, 3'd4, 1'b1, 1'b0, 32'd1};
    tbl[14] = '{1'b0, 32'd0,  1'b1, 3'd4, 1'b1, 1'b0, 32'd1};
    tbl[15] = '{1'b0, 32'd0,  1'b1, 3'd3, 1'b1, 1'b1, 32'd2};
    tbl[16] = '{1'b0, 32'd0,  1'b1, 3'd2, 1'b1, 1'b1, 32'd3};
    tbl[17] = '{1'b0, 32'd0,  1'b1, 3'd1, 1'b1, 1'b1, 32'd4};
    tbl[18] = '{1'b0, 32'd0,  1'b0, 3'd0, 1'b0, 1'b1, 32'd0};

    // Power-on reset, checked while asserted.
    #3;
    check("por_cmd_ready", 32'(cmd_ready), 32'd0);
    check("por_core_valid", 32'(core_cmd_valid), 32'd0);
    check("por_level", 32'(level), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    mdl_run = 1'b1;

    // Single push with stall, then fill to full and drain.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, 10'd0, tbl[i].i0, 32'd0, tbl[i].cr, 1'b0);
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
      check($sformatf("tbl%0d_core_valid", i), 32'(core_cmd_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_in0", i), core_cmd_payload_inputs_0, tbl[i].exp_i0);
      commit();
    end

    // Streaming: push and pop every cycle, pointers wrap several times.
    for (int i = 0; i <= 20; i++) begin
      drive(i < 20, 10'($urandom_range(0, 1023)), 32'(100 + i), $urandom, 1'b1, 1'b0);
      if (i > 0) begin
        check("stream_level", 32'(level), 32'd1);
        check("stream_in0", core_cmd_payload_inputs_0, 32'(99 + i));
      end
      commit();
    end

    // Flush with a simultaneous push: queue empties, the push is dropped.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 10'd7, 32'(200 + i), 32'(i), 1'b0, 1'b0);
    end
    drive(1'b1, 10'd9, 32'd999, 32'd999, 1'b0, 1'b1);
    check("flush_cmd_ready", 32'(cmd_ready), 32'd1);
    commit();
    drive(1'b0, 10'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("post_flush_level", 32'(level), 32'd0);
    check("post_flush_valid", 32'(core_cmd_valid), 32'd0);
    commit();
    step(1'b1, 10'd3, 32'd300, 32'd301, 1'b0, 1'b0);
    drive(1'b0, 10'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("post_flush_head", core_cmd_payload_inputs_0, 32'd300);
    commit();
    step(1'b0, 10'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Async reset with two entries queued; no stale payload afterwards.
    step(1'b1, 10'd5, 32'd400, 32'd401, 1'b0, 1'b0);
    step(1'b1, 10'd6, 32'd402, 32'd403, 1'b0, 1'b0);
    pulse_reset();
    drive(1'b0, 10'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("after_rst_level", 32'(level), 32'd0);
    check_cmd("after_rst_head", dut_head(), '0);
    commit();
    step(1'b1, 10'd11, 32'd500, 32'd501, 1'b0, 1'b0);
    step(1'b0, 10'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 10'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfu_cmd_queue.md
# cfu_cmd_queue

Command queue sitting directly upstream of a multi-cycle CFU compute core, such as the Fibonacci iterator, between the CPU's CFU command bus and the core's `cmd_*` port. It buffers up to DEPTH commands so the CPU can issue back-to-back commands while the core is busy iterating. Commands are forwarded in order, unmodified. The core's `rsp_*` path bypasses this block.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- ADDR_W, $clog2(DEPTH): derived; not to be overridden.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear of all queued commands.
- cmd_valid  in  1  CPU command valid.
- cmd_ready  out  1  queue can accept; reset 0 while reset asserted, 1 after.
- cmd_payload_function_id  in  10  function id.
- cmd_payload_inputs_0  in  32  operand 0.
- cmd_payload_inputs_1  in  32  operand 1.
- core_cmd_valid  out  1  head entry valid toward core; reset 0.
- core_cmd_ready  in  1  core accepts head entry.
- core_cmd_payload_function_id  out  10  head function id; 0 when empty.
- core_cmd_payload_inputs_0  out  32  head operand 0; 0 when empty.
- core_cmd_payload_inputs_1  out  32  head operand 1; 0 when empty.
- level  out  ADDR_W+1  entries held, 0..DEPTH; reset 0.

## Operation
- Push when cmd_valid & cmd_ready. Pop when core_cmd_valid & core_cmd_ready.
- Circular buffer: wr_ptr and rd_ptr are ADDR_W+1 bits wide, with the MSB used as the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- cmd_ready = !full & !reset_active. It never depends on core_cmd_ready: there is no combinational ready path through the block.
- core_cmd_valid = !empty. Payload outputs are driven from mem[rd_ptr] when non-empty and forced to 0 when empty.
- level = wr_ptr - rd_ptr, computed modulo 2^(ADDR_W+1).
- Push and pop in the same cycle:
  - level unchanged.
  - Legal at any non-full, non-empty level.
  - When full, no push occurs because cmd_ready=0.
  - When empty, no pop occurs because core_cmd_valid=0.
- flush has priority over push and pop. Both pointers return to 0 on the next edge, and any simultaneous push is dropped.
  - The CPU side is responsible for not issuing a command during flush.
  - cmd_ready stays asserted during flush when not full.
- Reset mid-operation discards all entries. Storage contents are not cleared, but they are never visible because of the zero-when-empty rule.
- Ordering is strict FIFO. Payload bits pass through unmodified.

## Timing
- No bypass: a command pushed at edge N is first presented on core_cmd_* in cycle N+1, i.e. 1 cycle of latency when the queue is empty.
- Throughput is 1 command per cycle in steady state.
- Full boundary: after the DEPTH-th push with no pop, cmd_ready is 0 in the following cycle. It returns to 1 in the cycle after a pop.
- Empty boundary: after the last pop, core_cmd_valid is 0 in the following cycle.
- The head payload must stay stable while core_cmd_valid=1 and core_cmd_ready=0.
- After reset deasserts, cmd_ready rises in the first cycle and level=0.

## Structure
- Package cfu_pkg holds:
  - CFU_FUNC_ID_W=10 and CFU_DATA_W=32.
  - Packed struct cfu_cmd_t {function_id, inputs_0, inputs_1} (74 bits), shared with the compute core and its testbench.
- Sub-module cfu_queue_mem: DEPTH x cfu_cmd_t register array with one write port and an asynchronous read port, no reset on the array.
- Pointer, flag and level logic live in cfu_cmd_queue.

## Test plan
- Reset, then idle → cmd_ready=1, core_cmd_valid=0, level=0, all core payloads 0.
- Single push of {fid=0, in0=10, in1=0} with core_cmd_ready=0 → core_cmd_valid=1 in the next cycle with in0=10, level=1. Payload stays stable for 5 stalled cycles. Raising core_cmd_ready pops it, and core_cmd_valid=0 in the following cycle.
- Fill with in0=1,2,3,4 with DEPTH=4 and core stalled → cmd_ready=0 and level=4. A 5th cmd_valid is not accepted. Draining yields 1,2,3,4 in order.
- Continuous push and pop for 20 cycles with in0=incrementing → level holds at 1. Output sequence equals the input sequence, delayed by 1 cycle. Pointers wrap without loss.
- Three entries queued, then flush asserted together with cmd_valid → next cycle level=0, core_cmd_valid=0, and the pushed command is absent.
- Two entries queued, then async reset pulsed mid-cycle → outputs go to reset values immediately. After release, level=0 and no stale payload is visible.
